// File: rtl/vertex_pe_sequencer_pkg.sv
// Shared types and sizing for the vertex PE sequencer and its MAC lanes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vertex_pe_sequencer_pkg;

    localparam int NUM_PE      = 4;
    localparam int MULT_PER_PE = 2;
    localparam int MAX_FV_NUM  = 16;
    localparam int FV_SIZE     = 16;
    localparam int NODE_ID_W   = 8;
    localparam int ACC_W       = 2*FV_SIZE + $clog2(MAX_FV_NUM);

    localparam int IDX_W = $clog2(MAX_FV_NUM);
    localparam int LEN_W = IDX_W + 1;
    localparam int PTR_W = $clog2(NUM_PE);

    typedef logic [NUM_PE-1:0][MULT_PER_PE-1:0][FV_SIZE-1:0] vertex_slice_t;
    typedef logic [MULT_PER_PE-1:0][FV_SIZE-1:0]             vertex_lane_t;

    typedef struct packed {
        logic [NODE_ID_W-1:0] node_id;
        logic [ACC_W-1:0]     data;
    } vertex_result_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    // Last start_idx to issue for a requested length: sub-stride bits are
    // dropped and an empty or oversized length means a full vector.
    function automatic logic [IDX_W-1:0] last_issue_idx(input logic [LEN_W-1:0] fv_len);
        logic [LEN_W-1:0] len;
        len = fv_len & ~LEN_W'(MULT_PER_PE - 1);
        if (len == '0 || len > LEN_W'(MAX_FV_NUM))
            len = LEN_W'(MAX_FV_NUM);
        return IDX_W'(len - LEN_W'(MULT_PER_PE));
    endfunction

endpackage

// File: rtl/vertex_mac_lane.sv
// One PE lane: MULT_PER_PE signed multipliers, adder tree, accumulator.
// Latency: accumulator updates on the edge that ends an enabled cycle.
// Backpressure: none; enable is driven by the sequencer.
module vertex_mac_lane
    import vertex_pe_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  vertex_lane_t     fv,
    input  vertex_lane_t     wgt,
    output logic [ACC_W-1:0] acc
);

    localparam int PW = 2*FV_SIZE;

    logic signed [ACC_W-1:0] sum;

    // Full-precision signed products summed into accumulator width.
    always_comb begin
        sum = '0;
        for (int j = 0; j < MULT_PER_PE; j++)
            sum = sum + ACC_W'(PW'($signed(fv[j])) * PW'($signed(wgt[j])));
    end

    // Accumulator: cleared at job start, adds one slice per enabled cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (enable)
            acc <= acc + sum;
    end

endmodule

// File: rtl/vertex_pe_sequencer.sv
// Walks station FV slices, MACs them against stored weights, streams results.
// Latency: fire -> complete after L/M+1 cycles; first beat the cycle after.
// Backpressure: beats hold stable while vbuf_ready is low.
module vertex_pe_sequencer
    import vertex_pe_sequencer_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 fire,
    input  logic [LEN_W-1:0]                     fv_len,
    input  logic [NUM_PE*MULT_PER_PE*FV_SIZE-1:0] rs_fv_data,
    input  logic [NUM_PE*NODE_ID_W-1:0]          rs_node_id,
    input  logic                                 wgt_wr_en,
    input  logic [IDX_W-1:0]                     wgt_wr_addr,
    input  logic [FV_SIZE-1:0]                   wgt_wr_data,
    output logic [IDX_W-1:0]                     start_idx,
    output logic                                 complete,
    output logic                                 out_valid,
    output logic [NODE_ID_W-1:0]                 out_node_id,
    output logic [ACC_W-1:0]                     out_data,
    input  logic                                 vbuf_ready,
    output logic                                 busy
);

    logic [1:0]                           state;
    logic [IDX_W-1:0]                     last_idx;
    logic [IDX_W-1:0]                     idx_d;
    logic                                 issue_d;
    logic [PTR_W-1:0]                     ptr;
    logic [NUM_PE-1:0][NODE_ID_W-1:0]     node_q;
    logic [MAX_FV_NUM-1:0][FV_SIZE-1:0]   wgt_ram;
    logic [NUM_PE-1:0][ACC_W-1:0]         acc;
    vertex_slice_t                        slice;
    vertex_lane_t                         lane_wgt;
    vertex_result_t                       beat;
    logic                                 acc_clr;

    assign slice   = rs_fv_data;
    assign acc_clr = (state == ST_IDLE) && fire;

    // Main sequencer: issue walk, one drain cycle, then the result stream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            start_idx <= '0;
            last_idx  <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    start_idx <= '0;
                    ptr       <= '0;
                    if (fire) begin
                        last_idx <= last_issue_idx(fv_len);
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (start_idx == last_idx) begin
                        start_idx <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        start_idx <= start_idx + IDX_W'(MULT_PER_PE);
                    end
                end
                ST_DRAIN: begin
                    ptr   <= '0;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (vbuf_ready) begin
                        if (ptr == PTR_W'(NUM_PE - 1)) begin
                            ptr   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            ptr <= ptr + PTR_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The station answers one cycle late, so MAC against the delayed index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_d <= 1'b0;
            idx_d   <= '0;
        end else begin
            issue_d <= (state == ST_ISSUE);
            idx_d   <= start_idx;
        end
    end

    // Node ids are frozen at drain so the station may move on during writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            node_q <= '0;
        else if (state == ST_DRAIN)
            node_q <= rs_node_id;
    end

    // Weight store; only writable between jobs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wgt_ram <= '0;
        else if ((state == ST_IDLE) && wgt_wr_en)
            wgt_ram[wgt_wr_addr] <= wgt_wr_data;
    end

    // Weight window shared by all lanes for the slice being accumulated.
    always_comb begin
        lane_wgt = '0;
        for (int j = 0; j < MULT_PER_PE; j++)
            lane_wgt[j] = wgt_ram[idx_d + IDX_W'(j)];
    end

    for (genvar pe = 0; pe < NUM_PE; pe++) begin : g_lane
        vertex_mac_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (acc_clr),
            .enable  (issue_d),
            .fv      (slice[pe]),
            .wgt     (lane_wgt),
            .acc     (acc[pe])
        );
    end

    // Result beat is forced to zero outside WRITE.
    always_comb begin
        beat = '0;
        if (state == ST_WRITE) begin
            beat.node_id = node_q[ptr];
            beat.data    = acc[ptr];
        end
    end

    assign out_node_id = beat.node_id;
    assign out_data    = beat.data;
    assign out_valid   = (state == ST_WRITE);
    assign complete    = (state == ST_DRAIN);
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_vertex_pe_sequencer.sv
// Self-checking bench: station model, dot-product reference, table of jobs.
// Latency: n/a.
// Backpressure: exercised via a vbuf_ready stall pattern.
module tb_vertex_pe_sequencer;
    import vertex_pe_sequencer_pkg::*;

    logic                                  clk = 1'b0;
    logic                                  reset_n = 1'b0;
    logic                                  fire = 1'b0;
    logic [LEN_W-1:0]                      fv_len = '0;
    logic [NUM_PE*MULT_PER_PE*FV_SIZE-1:0] rs_fv_data = '0;
    logic [NUM_PE*NODE_ID_W-1:0]           rs_node_id = '0;
    logic                                  wgt_wr_en = 1'b0;
    logic [IDX_W-1:0]                      wgt_wr_addr = '0;
    logic [FV_SIZE-1:0]                    wgt_wr_data = '0;
    logic [IDX_W-1:0]                      start_idx;
    logic                                  complete;
    logic                                  out_valid;
    logic [NODE_ID_W-1:0]                  out_node_id;
    logic [ACC_W-1:0]                      out_data;
    logic                                  vbuf_ready = 1'b1;
    logic                                  busy;

    vertex_pe_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fire        (fire),
        .fv_len      (fv_len),
        .rs_fv_data  (rs_fv_data),
        .rs_node_id  (rs_node_id),
        .wgt_wr_en   (wgt_wr_en),
        .wgt_wr_addr (wgt_wr_addr),
        .wgt_wr_data (wgt_wr_data),
        .start_idx   (start_idx),
        .complete    (complete),
        .out_valid   (out_valid),
        .out_node_id (out_node_id),
        .out_data    (out_data),
        .vbuf_ready  (vbuf_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     w_mem  [MAX_FV_NUM];
    int     fv_mem [NUM_PE][MAX_FV_NUM];
    int     ids    [NUM_PE];
    longint got_data [NUM_PE];
    bit     fire_wr = 1'b0;

    typedef struct {
        int fvl;    // requested fv_len
        int eff_l;  // effective length the job must walk
        int mode;   // 0 plain, 1 stall pattern, 2 disturbances
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Station: the slice for the index seen in cycle n is presented in cycle n+1.
    initial begin : station
        int idx_l;
        forever begin
            @(negedge clk);
            idx_l = int'(start_idx);
            @(posedge clk);
            #1;
            for (int pe = 0; pe < NUM_PE; pe++)
                for (int j = 0; j < MULT_PER_PE; j++)
                    rs_fv_data[(pe*MULT_PER_PE+j)*FV_SIZE +: FV_SIZE] = FV_SIZE'(fv_mem[pe][idx_l+j]);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic randomize_job();
        for (int k = 0; k < MAX_FV_NUM; k++) begin
            w_mem[k] = rnd16();
            for (int pe = 0; pe < NUM_PE; pe++) fv_mem[pe][k] = rnd16();
        end
        for (int pe = 0; pe < NUM_PE; pe++) ids[pe] = int'($urandom_range(0, 255));
    endtask

    task automatic load_weights();
        for (int k = 0; k < MAX_FV_NUM; k++) begin
            @(negedge clk);
            wgt_wr_en   = 1'b1;
            wgt_wr_addr = IDX_W'(k);
            wgt_wr_data = FV_SIZE'(w_mem[k]);
        end
        @(negedge clk);
        wgt_wr_en = 1'b0;
    endtask

    task automatic drive_ids();
        for (int pe = 0; pe < NUM_PE; pe++)
            rs_node_id[pe*NODE_ID_W +: NODE_ID_W] = NODE_ID_W'(ids[pe]);
    endtask

    task automatic run_case(input string nm, input int fvl, input int eff_l, input int mode);
        longint exp_v [NUM_PE];
        int     cyc, issued, accepted, t;
        bit     stalled;
        longint held;
        bit     pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        for (int pe = 0; pe < NUM_PE; pe++) begin
            exp_v[pe] = 0;
            for (int k = 0; k < eff_l; k++)
                exp_v[pe] += longint'(fv_mem[pe][k]) * longint'(w_mem[k]);
        end

        @(negedge clk);
        drive_ids();
        fv_len     = LEN_W'(fvl);
        vbuf_ready = 1'b1;
        fire       = 1'b1;
        if (fire_wr) begin
            wgt_wr_en   = 1'b1;
            wgt_wr_addr = IDX_W'(MAX_FV_NUM - 1);
            wgt_wr_data = FV_SIZE'(w_mem[MAX_FV_NUM-1]);
        end
        @(negedge clk);
        fire      = 1'b0;
        wgt_wr_en = 1'b0;
        cyc       = 1;
        issued    = 0;
        while (!complete && cyc < 40) begin
            chk({nm, " start_idx"}, longint'(start_idx), longint'((cyc-1)*MULT_PER_PE));
            issued++;
            fire = (mode == 2 && cyc == 2);
            @(negedge clk);
            cyc++;
        end
        fire = 1'b0;
        chk({nm, " complete_cycle"}, complete ? cyc : -1, eff_l/MULT_PER_PE + 1);
        chk({nm, " issue_count"}, issued, eff_l/MULT_PER_PE);

        @(negedge clk);
        chk({nm, " first_beat_valid"}, out_valid, 1);
        if (mode == 2) begin
            rs_node_id  = '1;
            wgt_wr_en   = 1'b1;
            wgt_wr_addr = '0;
            wgt_wr_data = 16'h7FFF;
        end
        accepted = 0;
        t        = 0;
        stalled  = 1'b0;
        held     = 0;
        while (accepted < NUM_PE && t < 64) begin
            if (mode == 1) vbuf_ready = pat[t % 4];
            if (stalled)
                chk({nm, " hold"}, longint'({out_node_id, out_data}), held);
            if (out_valid && vbuf_ready) begin
                chk({nm, " beat_id"}, longint'(out_node_id), longint'(ids[accepted]));
                got_data[accepted] = longint'($signed(out_data));
                chk({nm, " beat_data"}, got_data[accepted], exp_v[accepted]);
                accepted++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = longint'({out_node_id, out_data});
            end
            @(negedge clk);
            t++;
        end
        wgt_wr_en  = 1'b0;
        vbuf_ready = 1'b1;
        drive_ids();
        chk({nm, " beats_accepted"}, accepted, NUM_PE);
        chk({nm, " beat_cycles"}, t, (mode == 1) ? 8 : NUM_PE);
        chk({nm, " busy_after"}, busy, 0);
        chk({nm, " valid_after"}, out_valid, 0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, " start_idx"}, longint'(start_idx), 0);
        chk({nm, " complete"}, complete, 0);
        chk({nm, " out_valid"}, out_valid, 0);
        chk({nm, " out_node_id"}, longint'(out_node_id), 0);
        chk({nm, " out_data"}, longint'(out_data), 0);
        chk({nm, " busy"}, busy, 0);
    endtask

    initial begin : main
        vec_t tbl [9];
        tbl[0] = '{4, 4, 0};
        tbl[1] = '{16, 16, 0};
        tbl[2] = '{0, 16, 0};
        tbl[3] = '{5, 4, 0};
        tbl[4] = '{1, 16, 1};
        tbl[5] = '{17, 16, 0};
        tbl[6] = '{31, 16, 0};
        tbl[7] = '{7, 6, 1};
        tbl[8] = '{2, 2, 0};

        for (int k = 0; k < MAX_FV_NUM; k++) begin
            w_mem[k] = 0;
            for (int pe = 0; pe < NUM_PE; pe++) fv_mem[pe][k] = 0;
        end

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        chk_outputs_zero("reset_released");

        // Case 1: unit weights, known vectors.
        randomize_job();
        for (int k = 0; k < MAX_FV_NUM; k++) begin
            w_mem[k]     = 1;
            fv_mem[1][k] = -1;
        end
        for (int k = 0; k < 4; k++) fv_mem[0][k] = k + 1;
        for (int pe = 0; pe < NUM_PE; pe++) ids[pe] = 10 + pe;
        load_weights();
        run_case("t1", 4, 4, 0);
        chk("t1 pe0_value", got_data[0], 10);
        chk("t1 pe1_value", got_data[1], -4);

        // Case 4: disturbances during the same job, then a clean rerun.
        run_case("t4", 4, 4, 2);
        run_case("t4_rerun", 4, 4, 0);
        chk("t4 pe0_value", got_data[0], 10);
        chk("t4 pe1_value", got_data[1], -4);

        // Case 3: backpressure with the same job.
        run_case("t3", 4, 4, 1);

        // Case 2: ramp weights; the last weight is written in the fire cycle.
        for (int k = 0; k < MAX_FV_NUM; k++) begin
            w_mem[k]     = (k == MAX_FV_NUM-1) ? 0 : k;
            fv_mem[0][k] = 2;
        end
        load_weights();
        w_mem[MAX_FV_NUM-1] = MAX_FV_NUM - 1;
        fire_wr = 1'b1;
        run_case("t2", 16, 16, 0);
        fire_wr = 1'b0;
        chk("t2 pe0_value", got_data[0], 240);

        // Randomised jobs across the length-normalisation table.
        for (int i = 0; i < 9; i++) begin
            randomize_job();
            load_weights();
            run_case($sformatf("vec%0d", i), tbl[i].fvl, tbl[i].eff_l, tbl[i].mode);
        end

        // Case 6: asynchronous reset in the middle of an issue walk.
        randomize_job();
        load_weights();
        @(negedge clk);
        drive_ids();
        fv_len = LEN_W'(0);
        fire   = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6 busy_before_reset", busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("t6 async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < MAX_FV_NUM; k++) w_mem[k] = 0;
        run_case("t6_cleared_weights", 16, 16, 0);
        randomize_job();
        load_weights();
        run_case("t6_fresh", 6, 6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
